// File: rtl/event_recorder_if.sv
// Event record stream from the recorder to an off-block logger or trace buffer.
// A record transfers on a rising clk edge where evt_valid && evt_ready; while evt_valid is high
// and evt_ready is low, every evt_* payload field holds steady.
interface event_recorder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TS_WIDTH   = 32
);
  logic                  evt_valid;
  logic                  evt_ready;
  logic [2:0]            evt_level;
  logic                  evt_topic;
  logic [TS_WIDTH-1:0]   evt_time;
  logic [15:0]           evt_count;
  logic [DATA_WIDTH-1:0] evt_data;

  modport master (
    output evt_valid, evt_level, evt_topic, evt_time, evt_count, evt_data,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_level, evt_topic, evt_time, evt_count, evt_data,
    output evt_ready
  );
endinterface

// File: rtl/event_recorder.sv
// Hardware event recorder: a stability checker and a bounded-latency observer emit timestamped
// INFO/ERROR records into a small FIFO that drains over a valid/ready stream.
module event_recorder #(
  parameter int DATA_WIDTH = 8,
  parameter int TS_WIDTH   = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stbl_flag,
  input  logic [DATA_WIDTH-1:0] stbl_data,
  input  logic                  obs_start,
  input  logic                  obs_flag,
  input  logic [15:0]           obs_limit,
  event_recorder_if.master      evt,
  output logic [15:0]           dropped,
  output logic [1:0]            dbg_stbl_state,
  output logic                  dbg_obs_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] LVL_INFO  = 3'd2;
  localparam logic [2:0] LVL_ERROR = 3'd4;

  typedef struct packed {
    logic [2:0]            level;
    logic                  topic;
    logic [TS_WIDTH-1:0]   ts;
    logic [15:0]           count;
    logic [DATA_WIDTH-1:0] data;
  } rec_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TRACK = 2'd1, S_BROKEN = 2'd2} stbl_state_t;
  typedef enum logic {O_IDLE = 1'b0, O_WAIT = 1'b1} obs_state_t;

  logic [TS_WIDTH-1:0]   ts;
  stbl_state_t           stbl_state;
  logic [DATA_WIDTH-1:0] stbl_latch;
  logic [15:0]           stbl_cnt;
  obs_state_t            obs_state;
  logic [15:0]           obs_lim;
  logic [15:0]           obs_cnt;
  logic [15:0]           obs_cnt_inc;

  logic stbl_push, obs_push;
  rec_t stbl_rec, obs_rec;

  rec_t           mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, obs_wr_ptr;
  logic [CW-1:0]  fill, free;
  logic           not_empty, pop, acc_stbl, acc_obs;
  logic [1:0]     n_drop;
  logic [16:0]    drop_sum;
  rec_t           head;

  assign obs_cnt_inc = obs_cnt + 16'd1;

  always_comb begin
    stbl_push = 1'b0;
    stbl_rec  = '0;
    if (stbl_state == S_TRACK) begin
      if (!stbl_flag) begin
        stbl_push = 1'b1;
        stbl_rec  = '{level: LVL_INFO, topic: 1'b0, ts: ts, count: stbl_cnt, data: stbl_latch};
      end else if (stbl_data != stbl_latch) begin
        stbl_push = 1'b1;
        stbl_rec  = '{level: LVL_ERROR, topic: 1'b0, ts: ts, count: stbl_cnt, data: stbl_data};
      end
    end
  end

  // A budget of 1 expires in the start cycle itself, so it never enters WAIT.
  always_comb begin
    obs_push = 1'b0;
    obs_rec  = '0;
    if (obs_state == O_IDLE) begin
      if (obs_start) begin
        if (obs_limit == 16'd0) begin
          obs_push = 1'b1;
          obs_rec  = '{level: LVL_ERROR, topic: 1'b1, ts: ts, count: 16'd0, data: '0};
        end else if (obs_flag) begin
          obs_push = 1'b1;
          obs_rec  = '{level: LVL_INFO, topic: 1'b1, ts: ts, count: 16'd0, data: '0};
        end else if (obs_limit == 16'd1) begin
          obs_push = 1'b1;
          obs_rec  = '{level: LVL_ERROR, topic: 1'b1, ts: ts, count: obs_limit, data: '0};
        end
      end
    end else begin
      if (obs_flag) begin
        obs_push = 1'b1;
        obs_rec  = '{level: LVL_INFO, topic: 1'b1, ts: ts, count: obs_cnt, data: '0};
      end else if (obs_cnt_inc == obs_lim) begin
        obs_push = 1'b1;
        obs_rec  = '{level: LVL_ERROR, topic: 1'b1, ts: ts, count: obs_lim, data: '0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stbl_state <= S_IDLE;
      stbl_latch <= '0;
      stbl_cnt   <= '0;
    end else begin
      case (stbl_state)
        S_IDLE: if (stbl_flag) begin
          stbl_latch <= stbl_data;
          stbl_cnt   <= 16'd1;
          stbl_state <= S_TRACK;
        end
        S_TRACK: begin
          if (!stbl_flag)                   stbl_state <= S_IDLE;
          else if (stbl_data != stbl_latch) stbl_state <= S_BROKEN;
          else if (stbl_cnt != 16'hFFFF)    stbl_cnt   <= stbl_cnt + 16'd1;
        end
        S_BROKEN: if (!stbl_flag) stbl_state <= S_IDLE;
        default: stbl_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_state <= O_IDLE;
      obs_lim   <= '0;
      obs_cnt   <= '0;
    end else begin
      case (obs_state)
        O_IDLE: if (obs_start && obs_limit != 16'd0 && !obs_flag) begin
          obs_lim <= obs_limit;
          obs_cnt <= 16'd1;
          if (obs_limit != 16'd1) obs_state <= O_WAIT;
        end
        O_WAIT: begin
          if (obs_flag) begin
            obs_state <= O_IDLE;
          end else begin
            obs_cnt <= obs_cnt_inc;
            if (obs_cnt_inc == obs_lim) obs_state <= O_IDLE;
          end
        end
        default: obs_state <= O_IDLE;
      endcase
    end
  end

  // Space is judged before this cycle's pop, so a full FIFO drops even while draining.
  assign not_empty  = (fill != '0);
  assign pop        = not_empty && evt.evt_ready;
  assign free       = CW'(FIFO_DEPTH) - fill;
  assign acc_stbl   = stbl_push && (free != '0);
  assign acc_obs    = obs_push && (free > CW'(acc_stbl));
  assign obs_wr_ptr = wr_ptr + AW'(acc_stbl);
  assign n_drop     = {1'b0, stbl_push & ~acc_stbl} + {1'b0, obs_push & ~acc_obs};
  assign drop_sum   = {1'b0, dropped} + {15'd0, n_drop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts      <= '0;
      fill    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      dropped <= '0;
    end else begin
      ts      <= ts + 1'b1;
      fill    <= fill + CW'(acc_stbl) + CW'(acc_obs) - CW'(pop);
      wr_ptr  <= wr_ptr + AW'(acc_stbl) + AW'(acc_obs);
      rd_ptr  <= rd_ptr + AW'(pop);
      dropped <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (acc_stbl) mem[wr_ptr]     <= stbl_rec;
    if (acc_obs)  mem[obs_wr_ptr] <= obs_rec;
  end

  assign head          = mem[rd_ptr];
  assign evt.evt_valid = not_empty;
  assign evt.evt_level = not_empty ? head.level : 3'd0;
  assign evt.evt_topic = not_empty ? head.topic : 1'b0;
  assign evt.evt_time  = not_empty ? head.ts    : '0;
  assign evt.evt_count = not_empty ? head.count : 16'd0;
  assign evt.evt_data  = not_empty ? head.data  : '0;

  assign dbg_stbl_state = stbl_state;
  assign dbg_obs_state  = obs_state;

endmodule

// File: tb/tb_event_recorder.sv
// Bench for event_recorder: directed scenarios plus a randomized run, all scored against a
// run/elapsed-time reference model and a queue model of the record FIFO.
module tb_event_recorder;
  localparam int DW    = 8;
  localparam int TW    = 32;
  localparam int DEPTH = 8;
  localparam int RW    = 3 + 1 + TW + 16 + DW;
  localparam logic [2:0] INFO = 3'd2;
  localparam logic [2:0] ERR  = 3'd4;

  logic          clk, rst_n;
  logic          stbl_flag, obs_start, obs_flag;
  logic [DW-1:0] stbl_data;
  logic [15:0]   obs_limit, dropped;
  logic [1:0]    dbg_stbl_state;
  logic          dbg_obs_state;

  event_recorder_if #(.DATA_WIDTH(DW), .TS_WIDTH(TW)) evt ();

  event_recorder #(.DATA_WIDTH(DW), .TS_WIDTH(TW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stbl_flag(stbl_flag), .stbl_data(stbl_data),
    .obs_start(obs_start), .obs_flag(obs_flag), .obs_limit(obs_limit), .evt(evt),
    .dropped(dropped), .dbg_stbl_state(dbg_stbl_state), .dbg_obs_state(dbg_obs_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] pop_q[$];
  logic [RW-1:0] got_q[$];
  logic [TW-1:0] m_ts;
  int            m_cyc, drop_m;
  bit            run_on, run_bad;
  logic [DW-1:0] run_first;
  int            run_len;
  bit            obs_on;
  int            obs_t0, obs_lim;

  function automatic logic [RW-1:0] mk(input logic [2:0] lv, input logic tp, input logic [TW-1:0] t,
                                       input logic [15:0] c, input logic [DW-1:0] d);
    return {lv, tp, t, c, d};
  endfunction

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  function automatic logic [RW-1:0] head();
    return {evt.evt_level, evt.evt_topic, evt.evt_time, evt.evt_count, evt.evt_data};
  endfunction

  task automatic clear_model();
    exp_q.delete(); pop_q.delete(); got_q.delete();
    m_ts = '0; m_cyc = 0; drop_m = 0;
    run_on = 0; run_bad = 0; run_len = 0; run_first = '0;
    obs_on = 0; obs_t0 = 0; obs_lim = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    stbl_flag = 1'b0; stbl_data = '0; obs_start = 1'b0; obs_flag = 1'b0; obs_limit = '0;
    evt.evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_model();
  endtask

  // One clock: collect what the DUT hands over, predict this cycle's records and FIFO effect.
  task automatic step();
    logic [RW-1:0] pushes[$];
    int space, j;
    bit had;
    @(negedge clk);
    if (evt.evt_valid && evt.evt_ready) got_q.push_back(head());
    if (stbl_flag) begin
      if (!run_on) begin
        run_on = 1; run_bad = 0; run_first = stbl_data; run_len = 1;
      end else if (!run_bad) begin
        if (stbl_data != run_first) begin
          pushes.push_back(mk(ERR, 1'b0, m_ts, sat16(run_len), stbl_data));
          run_bad = 1;
        end else begin
          run_len++;
        end
      end
    end else if (run_on) begin
      if (!run_bad) pushes.push_back(mk(INFO, 1'b0, m_ts, sat16(run_len), run_first));
      run_on = 0;
    end
    if (!obs_on && obs_start) begin
      obs_on = 1; obs_lim = int'(obs_limit); obs_t0 = m_cyc;
    end
    if (obs_on) begin
      j = m_cyc - obs_t0;
      if (obs_lim == 0) begin
        pushes.push_back(mk(ERR, 1'b1, m_ts, 16'd0, '0)); obs_on = 0;
      end else if (obs_flag) begin
        pushes.push_back(mk(INFO, 1'b1, m_ts, 16'(j), '0)); obs_on = 0;
      end else if (j + 1 >= obs_lim) begin
        pushes.push_back(mk(ERR, 1'b1, m_ts, 16'(obs_lim), '0)); obs_on = 0;
      end
    end
    had = (exp_q.size() != 0);
    space = DEPTH - exp_q.size();
    foreach (pushes[k]) begin
      if (space > 0) begin
        exp_q.push_back(pushes[k]); space--;
      end else if (drop_m < 65535) begin
        drop_m++;
      end
    end
    if (had && evt.evt_ready) pop_q.push_back(exp_q.pop_front());
    m_ts++; m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (evt.evt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b exp 0", evt.evt_valid); end
    n_cmp++; if (head() !== '0) begin n_bad++; $display("FAIL reset_head got %h exp 0", head()); end
    n_cmp++; if (dropped !== 16'd0) begin n_bad++; $display("FAIL reset_dropped got %0d exp 0", dropped); end
    n_cmp++; if (dbg_stbl_state !== 2'd0 || dbg_obs_state !== 1'b0) begin
      n_bad++; $display("FAIL reset_state got %0d/%0d exp 0/0", dbg_stbl_state, dbg_obs_state);
    end
    evt.evt_ready = 1'b1;
    repeat (4) step();
    n_cmp++; if (evt.evt_valid !== 1'b0 || got_q.size() != 0) begin
      n_bad++; $display("FAIL reset_idle got valid %0b recs %0d exp 0 0", evt.evt_valid, got_q.size());
    end
  endtask

  task automatic test_stbl_info();
    apply_reset();
    evt.evt_ready = 1'b1;
    repeat (5) step();
    stbl_data = 8'hA5; stbl_flag = 1'b1;
    repeat (4) step();
    stbl_flag = 1'b0;
    repeat (4) step();
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL stbl_info_n got %0d exp 1", got_q.size()); end
    else begin
      n_cmp++; if (got_q[0] !== mk(INFO, 1'b0, 32'd9, 16'd4, 8'hA5)) begin
        n_bad++; $display("FAIL stbl_info_rec got %h exp %h", got_q[0], mk(INFO, 1'b0, 32'd9, 16'd4, 8'hA5));
      end
    end
  endtask

  task automatic test_stbl_error();
    apply_reset();
    evt.evt_ready = 1'b1;
    stbl_flag = 1'b1; stbl_data = 8'h3C;
    repeat (2) step();
    stbl_data = 8'h3D; step();
    stbl_data = 8'h00; step();
    stbl_flag = 1'b0;
    repeat (4) step();
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL stbl_err_n got %0d exp 1", got_q.size()); end
    else begin
      n_cmp++; if (got_q[0] !== mk(ERR, 1'b0, 32'd2, 16'd2, 8'h3D)) begin
        n_bad++; $display("FAIL stbl_err_rec got %h exp %h", got_q[0], mk(ERR, 1'b0, 32'd2, 16'd2, 8'h3D));
      end
    end
  endtask

  task automatic test_observe();
    logic [RW-1:0] want[5];
    logic [TW-1:0] t0;
    apply_reset();
    evt.evt_ready = 1'b1;
    t0 = m_ts; obs_limit = 16'd5; obs_start = 1'b1; step(); obs_start = 1'b0;
    repeat (2) step();
    obs_flag = 1'b1; step(); obs_flag = 1'b0;
    want[0] = mk(INFO, 1'b1, t0 + 3, 16'd3, '0);
    repeat (2) step();
    t0 = m_ts; obs_limit = 16'd5; obs_start = 1'b1; step();
    obs_limit = 16'd2; step(); obs_start = 1'b0;
    repeat (6) step();
    want[1] = mk(ERR, 1'b1, t0 + 4, 16'd5, '0);
    t0 = m_ts; obs_limit = 16'd0; obs_start = 1'b1; step(); obs_start = 1'b0;
    want[2] = mk(ERR, 1'b1, t0, 16'd0, '0);
    t0 = m_ts; obs_limit = 16'd1; obs_start = 1'b1; step(); obs_start = 1'b0;
    want[3] = mk(ERR, 1'b1, t0, 16'd1, '0);
    t0 = m_ts; obs_limit = 16'd7; obs_start = 1'b1; obs_flag = 1'b1; step();
    obs_start = 1'b0; obs_flag = 1'b0;
    want[4] = mk(INFO, 1'b1, t0, 16'd0, '0);
    repeat (4) step();
    n_cmp++; if (got_q.size() != 5) begin n_bad++; $display("FAIL obs_n got %0d exp 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== want[i]) begin
        n_bad++; $display("FAIL obs_rec%0d got %h exp %h", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] first;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      stbl_data = 8'(i); stbl_flag = 1'b1; step();
      stbl_flag = 1'b0; step();
    end
    first = mk(INFO, 1'b0, 32'd1, 16'd1, 8'd0);
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (evt.evt_valid !== 1'b1 || head() !== first) begin
        n_bad++; $display("FAIL bp_head c%0d got %b/%h exp 1/%h", c, evt.evt_valid, head(), first);
      end
      step();
    end
    n_cmp++; if (dropped !== 16'd2) begin n_bad++; $display("FAIL bp_dropped got %0d exp 2", dropped); end
    n_cmp++; if (int'(dropped) != drop_m) begin n_bad++; $display("FAIL bp_dropped_model got %0d exp %0d", dropped, drop_m); end
    evt.evt_ready = 1'b1;
    repeat (10) step();
    n_cmp++; if (got_q.size() != 8 || evt.evt_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_drain got %0d valid %0b exp 8 0", got_q.size(), evt.evt_valid);
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== mk(INFO, 1'b0, 32'(2 * i + 1), 16'd1, 8'(i))) begin
        n_bad++; $display("FAIL bp_rec%0d got %h exp %h", i, got_q[i], mk(INFO, 1'b0, 32'(2 * i + 1), 16'd1, 8'(i)));
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [TW-1:0] t1;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      stbl_data = 8'(i); stbl_flag = 1'b1; step();
      stbl_flag = 1'b0; step();
    end
    stbl_data = 8'h77; stbl_flag = 1'b1; step();
    t1 = m_ts;
    stbl_flag = 1'b0; obs_start = 1'b1; obs_limit = 16'd3; obs_flag = 1'b1; step();
    obs_start = 1'b0; obs_flag = 1'b0;
    n_cmp++; if (dropped !== 16'd1) begin n_bad++; $display("FAIL same_one_slot_dropped got %0d exp 1", dropped); end
    evt.evt_ready = 1'b1;
    repeat (10) step();
    n_cmp++; if (got_q.size() != 8) begin n_bad++; $display("FAIL same_one_slot_n got %0d exp 8", got_q.size()); end
    else begin
      n_cmp++; if (got_q[7] !== mk(INFO, 1'b0, t1, 16'd1, 8'h77)) begin
        n_bad++; $display("FAIL same_one_slot_rec got %h exp %h", got_q[7], mk(INFO, 1'b0, t1, 16'd1, 8'h77));
      end
    end
    stbl_data = 8'h55; stbl_flag = 1'b1; step();
    t1 = m_ts;
    stbl_flag = 1'b0; obs_start = 1'b1; obs_limit = 16'd3; obs_flag = 1'b1; step();
    obs_start = 1'b0; obs_flag = 1'b0;
    repeat (4) step();
    n_cmp++; if (got_q.size() != 10 || dropped !== 16'd1) begin
      n_bad++; $display("FAIL same_two_slot_n got %0d drop %0d exp 10 1", got_q.size(), dropped);
    end else begin
      n_cmp++; if (got_q[8] !== mk(INFO, 1'b0, t1, 16'd1, 8'h55) || got_q[9] !== mk(INFO, 1'b1, t1, 16'd0, '0)) begin
        n_bad++; $display("FAIL same_two_slot_order got %h %h exp %h %h", got_q[8], got_q[9],
                          mk(INFO, 1'b0, t1, 16'd1, 8'h55), mk(INFO, 1'b1, t1, 16'd0, '0));
      end
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      stbl_data = 8'(i + 1); stbl_flag = 1'b1; step();
      stbl_flag = 1'b0; step();
    end
    stbl_data = 8'h11; stbl_flag = 1'b1; step();
    obs_limit = 16'd20; obs_start = 1'b1; step(); obs_start = 1'b0;
    n_cmp++; if (evt.evt_valid !== 1'b1 || dbg_stbl_state === 2'd0 || dbg_obs_state !== 1'b1) begin
      n_bad++; $display("FAIL midflight_setup got valid %0b st %0d/%0d exp 1 busy", evt.evt_valid, dbg_stbl_state, dbg_obs_state);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (evt.evt_valid !== 1'b0 || dropped !== 16'd0 || dbg_stbl_state !== 2'd0 || dbg_obs_state !== 1'b0) begin
      n_bad++; $display("FAIL midflight_async got valid %0b drop %0d st %0d/%0d exp 0 0 0/0",
                        evt.evt_valid, dropped, dbg_stbl_state, dbg_obs_state);
    end
    apply_reset();
    evt.evt_ready = 1'b1;
    stbl_data = 8'h22; stbl_flag = 1'b1;
    repeat (2) step();
    stbl_flag = 1'b0;
    repeat (25) step();
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL midflight_stale got %0d exp 1", got_q.size()); end
    else begin
      n_cmp++; if (got_q[0] !== mk(INFO, 1'b0, 32'd2, 16'd2, 8'h22)) begin
        n_bad++; $display("FAIL midflight_ts got %h exp %h", got_q[0], mk(INFO, 1'b0, 32'd2, 16'd2, 8'h22));
      end
    end
  endtask

  task automatic test_random();
    int n;
    apply_reset();
    for (int i = 0; i < 1800; i++) begin
      if ($urandom_range(0, 3) == 0) stbl_flag = ~stbl_flag;
      if ($urandom_range(0, 9) == 0) stbl_data = 8'($urandom_range(0, 3));
      obs_start = ($urandom_range(0, 9) == 0);
      obs_limit = 16'($urandom_range(0, 8));
      obs_flag  = ($urandom_range(0, 6) == 0);
      evt.evt_ready = ((i / 300) % 2 == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end
    stbl_flag = 1'b0; obs_start = 1'b0; obs_flag = 1'b0; evt.evt_ready = 1'b1;
    repeat (40) step();
    n_cmp++; if (got_q.size() != pop_q.size()) begin
      n_bad++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), pop_q.size());
    end
    n = (got_q.size() < pop_q.size()) ? got_q.size() : pop_q.size();
    for (int i = 0; i < n; i++) begin
      n_cmp++; if (got_q[i] !== pop_q[i]) begin
        n_bad++; $display("FAIL rand_rec%0d got %h exp %h", i, got_q[i], pop_q[i]);
      end
    end
    n_cmp++; if (int'(dropped) != drop_m) begin n_bad++; $display("FAIL rand_dropped got %0d exp %0d", dropped, drop_m); end
    n_cmp++; if (evt.evt_valid !== 1'b0) begin n_bad++; $display("FAIL rand_empty got %0b exp 0", evt.evt_valid); end
  endtask

  initial begin
    test_reset();
    test_stbl_info();
    test_stbl_error();
    test_observe();
    test_backpressure();
    test_same_cycle();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/event_recorder.md
Name: event_recorder

Overview:
- Synthesizable, in-design counterpart of the simulation event log.
- Watches a data/flag pair for stability violations and watches a flag for a bounded-latency arrival.
- Produces timestamped INFO/ERROR event records. Records drain through a valid/ready stream to an off-block logger or trace buffer.
- Sits beside a DUT in emulation builds, so checks made by the bench at simulation time can run in hardware.

Parameters:
DATA_WIDTH, 8, width of monitored data bus and of evt_data
TS_WIDTH, 32, width of free-running timestamp
FIFO_DEPTH, 8, record FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
stbl_flag  in  1  data must hold constant while high
stbl_data  in  DATA_WIDTH  data under stability check
obs_start  in  1  one-cycle pulse: begin observing obs_flag
obs_flag  in  1  condition being waited for
obs_limit  in  16  cycle budget, sampled on obs_start
evt_valid  out  1  FIFO head record valid
evt_ready  in  1  consumer accepts head record
evt_level  out  3  2=INFO, 4=ERROR (tone encoding)
evt_topic  out  1  0=ASSERT_STBL, 1=OBSERVE
evt_time  out  TS_WIDTH  timestamp of detecting cycle
evt_count  out  16  cycle count carried by record
evt_data  out  DATA_WIDTH  data carried by record (0 for OBSERVE)
dropped  out  16  records lost to FIFO full, saturating

Behaviour:
Reset and timestamp:
- rst_n low, at any time: FSMs to IDLE, FIFO emptied, timestamp=0, dropped=0, all outputs 0. A record in flight is discarded.
- Timestamp increments every cycle and wraps at 2^TS_WIDTH.

Stability FSM (IDLE/TRACK/BROKEN):
- IDLE, stbl_flag=1: latch stbl_data, cnt=1, go TRACK.
- TRACK, flag=1, data==latch: cnt+1, saturating at 0xFFFF.
- TRACK, flag=1, data!=latch: push ERROR/STBL, evt_data=new data, evt_count=cnt, go BROKEN.
- TRACK, flag=0: push INFO/STBL, evt_data=latch, evt_count=cnt, go IDLE.
- BROKEN: further changes produce no record. flag=0 returns to IDLE silently.
- Flag low->high->low lasting one cycle gives INFO with count 1.

Observe FSM (IDLE/WAIT):
- IDLE, obs_start=1: latch obs_limit as L.
  - L=0: push ERROR/OBSERVE, count 0.
  - Else obs_flag=1: push INFO, count 0.
  - Else cnt=1. If cnt==L, push ERROR with count L; otherwise go WAIT.
- WAIT, obs_flag=1: push INFO, count=cnt, go IDLE.
- WAIT, obs_flag=0: cnt+1. On reaching L, push ERROR with count L, go IDLE.
- obs_start in WAIT is ignored.

FIFO and arbitration:
- Up to two pushes per cycle, STBL first, then OBSERVE.
- Free space is computed before the same-cycle pop; there is no bypass.
- One slot free: STBL written, OBSERVE dropped. Zero free: both dropped.
- Each lost record increments dropped, saturating at 0xFFFF.

Output stream:
- evt_valid = FIFO not empty. Head fields are stable while evt_valid=1 and evt_ready=0.
- Pop on evt_valid & evt_ready.
- Record detected in cycle N is visible at the FIFO head no earlier than cycle N+1.
- evt_time equals the timestamp during cycle N.

Test Plan:
- Reset release, stbl_flag high at ts=5 for 4 cycles with data 0xA5 constant, evt_ready=1 -> one record: INFO/STBL, count 4, data 0xA5, evt_time 9.
- stbl_flag high, data 0x3C then 0x3D on 3rd cycle, then 0x00, then flag low -> exactly one ERROR/STBL, count 2, data 0x3D; no INFO after.
- obs_start with obs_limit=5, obs_flag rising 3 cycles later -> INFO/OBSERVE, count 3. Repeat with flag never rising -> ERROR, count 5. obs_limit=0 -> immediate ERROR, count 0.
- evt_ready=0, generate 10 STBL INFO records with FIFO_DEPTH=8 -> evt_valid=1, head unchanged, dropped=2. Release ready -> 8 records in order.
- Same-cycle STBL end and OBSERVE hit with 1 free slot -> STBL stored, dropped+1. With >=2 free -> STBL then OBSERVE popped in that order.
- rst_n low mid-TRACK and mid-WAIT with 3 records queued -> evt_valid=0 immediately (async). After release, timestamp restarts at 0 and no stale records appear.
